// File: rtl/reduce_arbiter.sv
// Purpose: round-robin share of one pipelined tree_reduce among NUM_REQ lanes, with in-order tag return routing.
// Latency: zero added cycles on both issue (req -> tree) and return (tree -> rsp); both paths are combinational.
// Backpressure: issue stalls on tree_rdy_out or a full tag FIFO; a stalled head requester holds off the tree output.
module reduce_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int LEN          = 64,
   parameter int W_IN         = 16,
   parameter int W_OUT        = W_IN + $clog2(LEN),
   parameter int MAX_INFLIGHT = 8,                 // power of 2, >= 2, >= tree latency
   parameter int ID_W         = $clog2(NUM_REQ)
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  logic [NUM_REQ-1:0]                      req_vld_i,
   output logic [NUM_REQ-1:0]                      req_rdy_o,
   input  logic [NUM_REQ-1:0][LEN-1:0][W_IN-1:0]   req_list_i,
   output logic                                    tree_vld_in_o,
   input  logic                                    tree_rdy_out_i,
   output logic [LEN-1:0][W_IN-1:0]                tree_list_o,
   input  logic                                    tree_vld_out_i,
   output logic                                    tree_rdy_in_o,
   input  logic signed [W_OUT-1:0]                 tree_sum_i,
   output logic [NUM_REQ-1:0]                      rsp_vld_o,
   input  logic [NUM_REQ-1:0]                      rsp_rdy_i,
   output logic signed [W_OUT-1:0]                 rsp_sum_o,
   output logic [ID_W-1:0]                         rsp_id_o,
   output logic [$clog2(MAX_INFLIGHT):0]           inflight_o,
   output logic                                    err_orphan_o
);

   localparam int PTR_W = $clog2(MAX_INFLIGHT);

   // round-robin pointer
   logic [ID_W-1:0]  rr_q, rr_d;

   // in-order tag FIFO: one requester ID per vector currently inside the tree
   logic [ID_W-1:0]  tag_q [MAX_INFLIGHT];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   cnt_q, cnt_d;

   logic             err_q, err_d;

   logic [ID_W-1:0]  winner;
   logic [ID_W-1:0]  cand;
   logic [ID_W-1:0]  sel;
   logic             found;
   logic             full;
   logic             not_empty;
   logic             can_issue;
   logic             push;
   logic             pop;

   // pick the first valid requester at or after rr_q, wrapping around
   always_comb begin
      winner = rr_q;
      cand   = rr_q;
      found  = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = ID_W'((int'(rr_q) + off) % NUM_REQ);
         if (!found && req_vld_i[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // A full FIFO blocks issue even when a pop happens in the same cycle, so the
   // ready path never depends on the return path. Reset gates the grant so no
   // requester sees a handshake while the tag FIFO is being cleared.
   assign full      = (cnt_q == (PTR_W+1)'(MAX_INFLIGHT));
   assign not_empty = (cnt_q != '0);
   assign can_issue = rst_ni & tree_rdy_out_i & ~full & found;
   assign push      = can_issue;

   assign tree_vld_in_o = can_issue;
   assign req_rdy_o     = can_issue ? (NUM_REQ'(1) << winner) : '0;

   // When idle the tree list is a don't-care; park it on the pointer lane.
   assign sel         = can_issue ? winner : rr_q;
   assign tree_list_o = req_list_i[sel];

   // return routing: the FIFO head names the owner of the sum at the tree output
   assign rsp_id_o      = tag_q[head_q];
   assign tree_rdy_in_o = not_empty & rsp_rdy_i[rsp_id_o];
   assign pop           = tree_vld_out_i & tree_rdy_in_o;
   assign rsp_sum_o     = tree_sum_i;
   assign inflight_o    = cnt_q;
   assign err_orphan_o  = err_q;

   // decode the head tag into a one-hot valid towards the requesters
   always_comb begin
      rsp_vld_o = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         rsp_vld_o[r] = tree_vld_out_i & not_empty & (rsp_id_o == ID_W'(r));
      end
   end

   // next-state for pointer, FIFO occupancy and the sticky orphan flag
   always_comb begin
      rr_d   = rr_q;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      err_d  = err_q | (tree_vld_out_i & ~not_empty);
      if (push) begin
         rr_d   = (int'(winner) == NUM_REQ-1) ? '0 : winner + 1'b1;
         tail_d = tail_q + 1'b1;
      end
      if (pop) begin
         head_d = head_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // state registers; reset drops every in-flight tag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q   <= '0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
         for (int i = 0; i < MAX_INFLIGHT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         rr_q   <= rr_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
         if (push) begin
            tag_q[tail_q] <= winner;
         end
      end
   end

endmodule
